// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: LUI/OR/ADD resolve in one cycle, SLL shifts one bit per cycle.
// A start/busy/done handshake lets the datapath FSM stall until the result is ready.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_data_i,
    input  logic [DATA_WIDTH-1:0]  b_data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  alu_data_o,
    output logic                   zero_o,
    output logic                   invalid_op_o
);

    localparam logic [3:0] OP_LUI = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  acc_q;
    logic [SHAMT_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0]  alu_data_q;
    logic                   zero_q;
    logic                   invalid_q;

    logic [DATA_WIDTH-1:0]  result_d;
    logic                   invalid_d;
    logic [DATA_WIDTH-1:0]  acc_shl_d;

    // Single-cycle result; SLL only reaches here when shamt_i is zero.
    always_comb begin
        result_d  = '0;
        invalid_d = 1'b0;
        case (alu_operation_i)
            OP_LUI:  result_d = b_data_i << 16;
            OP_OR:   result_d = a_data_i | b_data_i;
            OP_SLL:  result_d = b_data_i;
            OP_ADD:  result_d = a_data_i + b_data_i;
            default: invalid_d = 1'b1;
        endcase
    end

    assign acc_shl_d = acc_q << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            alu_data_q <= '0;
            zero_q     <= 1'b1;
            invalid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (alu_operation_i == OP_SLL && shamt_i != '0) begin
                            acc_q   <= b_data_i;
                            count_q <= shamt_i;
                            state_q <= SHIFT;
                        end else begin
                            alu_data_q <= result_d;
                            zero_q     <= (result_d == '0);
                            invalid_q  <= invalid_d;
                            state_q    <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_shl_d;
                    count_q <= count_q - 1'b1;
                    if (count_q == SHAMT_WIDTH'(1)) begin
                        alu_data_q <= acc_shl_d;
                        zero_q     <= (acc_shl_d == '0);
                        invalid_q  <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign alu_data_o   = alu_data_q;
    assign zero_o       = zero_q;
    assign invalid_op_o = invalid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results are queued at start and checked at done_o.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [3:0]  alu_operation_i;
    logic [31:0] a_data_i;
    logic [31:0] b_data_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] alu_data_o;
    logic        zero_o;
    logic        invalid_op_o;

    typedef struct {
        logic [31:0] d;
        logic        z;
        logic        inv;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .alu_operation_i(alu_operation_i),
        .a_data_i       (a_data_i),
        .b_data_i       (b_data_i),
        .shamt_i        (shamt_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .alu_data_o     (alu_data_o),
        .zero_o         (zero_o),
        .invalid_op_o   (invalid_op_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        e.inv = 1'b0;
        case (op)
            4'd0:    e.d = {b[15:0], 16'h0000};
            4'd1:    e.d = a | b;
            4'd2:    e.d = b << sh;
            4'd3:    e.d = a + b;
            default: begin e.d = 32'h0; e.inv = 1'b1; end
        endcase
        e.z = (e.d == 32'h0);
        return e;
    endfunction

    // Drives a one-cycle start and queues the expected result; returns in cycle 1 after the start edge.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] sh);
        alu_operation_i = op;
        a_data_i        = a;
        b_data_i        = b;
        shamt_i         = sh;
        start_i         = 1'b1;
        sb.push_back(model(op, a, b, sh));
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int lat, input string tag);
        int   n = n0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (done_o !== 1'b1 && n < 70) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({31'h0, done_o}, 32'h1, {tag, "_done"});
        check(n, lat, {tag, "_latency"});
        check({31'h0, busy_o & busy_ok}, 32'h1, {tag, "_busy"});
        if (sb.size() == 0) begin
            check(32'h0, 32'h1, {tag, "_scoreboard_empty"});
        end else begin
            e = sb.pop_front();
            check(alu_data_o, e.d, {tag, "_data"});
            check({31'h0, zero_o}, {31'h0, e.z}, {tag, "_zero"});
            check({31'h0, invalid_op_o}, {31'h0, e.inv}, {tag, "_invalid"});
        end
    endtask

    task automatic after_done(input string tag);
        tick();
        check({30'h0, busy_o, done_o}, 32'h0, {tag, "_idle_after"});
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input int lat, input string tag);
        start_op(op, a, b, sh);
        wait_done(1, lat, tag);
        after_done(tag);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1;
        start_i = 1'b0;
        alu_operation_i = 4'h0;
        a_data_i = '0;
        b_data_i = '0;
        shamt_i = '0;
        tick();
        tick();
        check({30'h0, busy_o, done_o}, 32'h0, "reset_busy_done");
        check(alu_data_o, 32'h0, "reset_data");
        check({30'h0, zero_o, invalid_op_o}, 32'h2, "reset_zero_inv");
        reset = 1'b0;
        tick();

        run_op(4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 1, "add_ovf");
        run_op(4'd3, 32'hFFFF_FFFF, 32'h1, 5'd0, 1, "add_wrap");
        run_op(4'd0, 32'h1111_1111, 32'h0000_ABCD, 5'd7, 1, "lui");
        run_op(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, 1, "or");
        run_op(4'd2, 32'h0, 32'h1, 5'd31, 32, "sll31");
        run_op(4'd2, 32'h0, 32'h0000_1234, 5'd0, 1, "sll0");
        run_op(4'd2, 32'h0, 32'hC000_0001, 5'd1, 2, "sll1_lost");
        run_op(4'd9, 32'h5, 32'h6, 5'd0, 1, "op1001");
        run_op(4'd7, 32'h5, 32'h6, 5'd0, 1, "op0111");
        run_op(4'd3, 32'h2, 32'h3, 5'd0, 1, "add_clr_inv");

        // Starts during SHIFT and during DONE must be dropped.
        start_op(4'd2, 32'h0, 32'h0000_0003, 5'd5);
        tick();
        alu_operation_i = 4'd3;
        a_data_i = 32'h1;
        b_data_i = 32'h1;
        shamt_i = 5'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(3, 6, "sll5_ignore");
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({30'h0, busy_o, done_o}, 32'h0, "sll5_ignore_done_start");
        tick();
        check({31'h0, done_o}, 32'h0, "sll5_single_done");
        check(alu_data_o, 32'h0000_0060, "sll5_held");

        // Reset mid-shift aborts the op without a done pulse.
        start_op(4'd2, 32'h0, 32'h0000_00FF, 5'd10);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_front());
        check({30'h0, busy_o, done_o}, 32'h0, "abort_busy_done");
        check(alu_data_o, 32'h0, "abort_data");
        check({30'h0, zero_o, invalid_op_o}, 32'h2, "abort_zero_inv");
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_o !== 1'b0 || busy_o !== 1'b0) saw_done = 1'b1;
            tick();
        end
        check({31'h0, saw_done}, 32'h0, "abort_no_done");
        run_op(4'd3, 32'h0000_0005, 32'h0000_0006, 5'd0, 1, "add_after_abort");

        check(sb.size(), 32'h0, "scoreboard_drained");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
